note_judge: RTL
===============

Name: note_judge

Overview:
- Receiving end of the note-lane interface driven by the song loader.
- Watches the judge-position outputs (note_R_judge / note_B_judge) and the pixel offset, and debounces the red and blue player buttons.
- Grades each press, returns a one-cycle delete pulse to the loader on a hit, and keeps score, combo and max combo for the display.
- Sits between the button pins, the loader and the score/LED display logic.

Parameters:
- DEBOUNCE_CYCLES, 20'd999999, cycles a synchronized button level must stay stable before it is accepted
- PERFECT_MAX_OFS, 3'd2, offsets 0..PERFECT_MAX_OFS grade PERFECT; larger offsets grade GOOD
- PERFECT_PTS, 4'd3, points added for PERFECT
- GOOD_PTS, 4'd1, points added for GOOD

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- red_button  in  1  raw red button, asynchronous to clk
- blue_button  in  1  raw blue button, asynchronous to clk
- note_R_judge  in  1  red note present at judge position
- note_B_judge  in  1  blue note present at judge position
- offset  in  3  loader pixel offset, 0..6
- finish  in  1  song finished, level
- delete  out  1  one-cycle pulse that clears the judge-position note in the loader
- grade  out  2  last result: 0 none, 1 MISS, 2 GOOD, 3 PERFECT
- score  out  16  accumulated points
- combo  out  8  consecutive hits
- max_combo  out  8  highest combo reached this song

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, synchronizers, debounce counters and lane flags cleared. Reset mid-song aborts scoring immediately.
- Buttons:
  - 2-flop synchronizer, then a per-button debounce counter. The counter resets whenever the synchronized level differs from the accepted level; when it reaches DEBOUNCE_CYCLES-1 the new level is accepted.
  - A 0->1 change of the accepted level gives press_r / press_b, one-cycle internal pulses.
- FSM states IDLE, PLAY, DONE:
  - IDLE -> PLAY on the first cycle either note_R_judge or note_B_judge is 1; score, combo, max_combo and grade clear on this transition.
  - PLAY -> DONE when finish = 1.
  - DONE -> IDLE when finish = 0.
  - In IDLE and DONE, presses and lane events are ignored; delete stays 0 and the counters hold.
- Judging, PLAY only. All results register one cycle after the press pulse or lane event; delete has 1-cycle latency and is high for exactly one cycle.
  - Hit: press_r with note_R_judge = 1 and lane-R hit flag = 0 (blue symmetric). Actions: delete = 1; grade = PERFECT if offset <= PERFECT_MAX_OFS, else GOOD; add the matching points; combo + 1; set the lane hit flag.
  - Wrong press: press with no matching note present, or that lane's hit flag already set. Actions: grade = MISS, combo = 0, no delete.
  - Both press pulses in the same cycle: treated as a single wrong press (MISS, combo 0, no delete), even if one would hit.
  - Missed note: falling edge of note_X_judge while that lane's hit flag = 0 gives grade = MISS and combo = 0. A falling edge clears the lane hit flag in either case.
  - A missed-note event and a hit on the other lane in the same cycle: the hit is applied first, then combo = 0. Score keeps the hit's points; grade = MISS.
- Arithmetic and saturation:
  - score saturates at 16'hFFFF.
  - combo saturates at 8'd255.
  - max_combo updates in the same cycle as combo whenever the new combo exceeds it.
- grade holds its last value until the next event.

Test Plan:
- Reset, then press red with note_R_judge = 1 and offset = 1: delete high 1 cycle after the press pulse; grade = 3, score = 3, combo = 1, max_combo = 1.
- Red note present, offset = 5, press red: grade = 2, score + 1, combo + 1. A second red press before note_R_judge falls: MISS, combo = 0, no second delete.
- Pulse note_B_judge high then low with no press: grade = 1, combo = 0, score unchanged.
- Press red and blue in the same cycle with a red note present: MISS, no delete, combo = 0.
- Bounce red_button 5 times within DEBOUNCE_CYCLES (use a small value, e.g. 8): exactly one press is recognised.
- Preload combo = 255 and press 300 hits: combo stays 255. Separately, assert finish mid-song: further presses produce no delete; state is DONE and the counters hold. Assert rst mid-song: all outputs 0 next cycle.

Source files
------------

// File: rtl/note_judge.sv
// rtl/note_judge.sv - judges red/blue button presses against the loader's judge-position notes
// Keeps score, combo and max combo, and pulses delete back to the loader on every hit.
module note_judge #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd999999,
  parameter logic [2:0]  PERFECT_MAX_OFS = 3'd2,
  parameter logic [3:0]  PERFECT_PTS     = 4'd3,
  parameter logic [3:0]  GOOD_PTS        = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        note_R_judge,
  input  logic        note_B_judge,
  input  logic [2:0]  offset,
  input  logic        finish,
  output logic        delete,
  output logic [1:0]  grade,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo
);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [1:0] GRADE_MISS    = 2'd1;
  localparam logic [1:0] GRADE_GOOD    = 2'd2;
  localparam logic [1:0] GRADE_PERFECT = 2'd3;

  state_t      state, state_next;
  logic [1:0]  raw, sync1, sync2, level, press;
  logic [19:0] cnt [2];
  logic        note_r_q, note_b_q, flag_r, flag_b;
  logic        fall_r, fall_b, hit_r, hit_b, hit, wrong, miss, perfect;
  logic [3:0]  pts;
  logic [16:0] score_sum;
  logic [7:0]  combo_inc;

  assign raw = {blue_button, red_button};

  // Index 0 is red, index 1 is blue; press fires on the cycle a new high level is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      level  <= '0;
      press  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
          cnt[i]   <= '0;
          level[i] <= sync2[i];
          press[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 20'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (note_R_judge || note_B_judge) state_next = PLAY;
      PLAY:    if (finish) state_next = DONE;
      DONE:    if (!finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fall_r    = note_r_q & ~note_R_judge;
    fall_b    = note_b_q & ~note_B_judge;
    hit_r     = press[0] & ~press[1] & note_R_judge & ~flag_r;
    hit_b     = press[1] & ~press[0] & note_B_judge & ~flag_b;
    hit       = hit_r | hit_b;
    wrong     = (press[0] | press[1]) & ~hit;
    miss      = (fall_r & ~flag_r) | (fall_b & ~flag_b);
    perfect   = (offset <= PERFECT_MAX_OFS);
    pts       = perfect ? PERFECT_PTS : GOOD_PTS;
    score_sum = {1'b0, score} + {13'd0, pts};
    combo_inc = (combo == 8'hFF) ? 8'hFF : combo + 8'd1;
  end

  // A hit and a miss in the same cycle: the hit scores, then the miss zeroes combo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_r_q  <= 1'b0;
      note_b_q  <= 1'b0;
      flag_r    <= 1'b0;
      flag_b    <= 1'b0;
      delete    <= 1'b0;
      grade     <= '0;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else begin
      note_r_q <= note_R_judge;
      note_b_q <= note_B_judge;
      delete   <= 1'b0;
      if (fall_r) flag_r <= 1'b0;
      if (fall_b) flag_b <= 1'b0;
      if (state == IDLE && state_next == PLAY) begin
        grade     <= '0;
        score     <= '0;
        combo     <= '0;
        max_combo <= '0;
      end else if (state == PLAY) begin
        if (hit) begin
          delete <= 1'b1;
          grade  <= perfect ? GRADE_PERFECT : GRADE_GOOD;
          score  <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          combo  <= combo_inc;
          if (combo_inc > max_combo) max_combo <= combo_inc;
          if (hit_r) flag_r <= 1'b1;
          if (hit_b) flag_b <= 1'b1;
        end
        if (wrong || miss) begin
          grade <= GRADE_MISS;
          combo <= '0;
        end
      end
    end
  end

endmodule
